// File: rtl/rc_meas_sequencer_pkg.sv
// Shared types and constants for the RC time-to-digital measurement sequencer.
package rc_tdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    DISCHARGE,
    RESULT
  } state_e;

  localparam int unsigned CNT_W           = 24;
  localparam int unsigned DISCHARGE_SHIFT = 2;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

endpackage

// File: rtl/rc_meas_sequencer_if.sv
// Result handshake bundle between the sequencer and the resistance-calculation path.
interface rc_meas_sequencer_if #(
  parameter int unsigned CNT_W = 24
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_count;
  logic             meas_overflow;

  modport master (output meas_valid, output meas_count, output meas_overflow, input meas_ready);
  modport slave  (input meas_valid, input meas_count, input meas_overflow, output meas_ready);
endinterface

// File: rtl/rc_meas_sequencer_sync.sv
// Reset-to-0 multi-stage bit synchronizer for the asynchronous RC comparator.
module rc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rc_meas_sequencer.sv
// RC charge-time measurement sequencer: charge/discharge FSM, sample averaging, result handshake.
// Optional macro RC_AUTORUN_EN: after each result handshake restart charging instead of idling.
module rc_meas_sequencer #(
  parameter int unsigned      CNT_W         = rc_tdc_pkg::CNT_W,
  parameter int unsigned      AVG_LOG2      = 2,
  parameter logic [CNT_W-1:0] MIN_DISCHARGE = 1000,
  parameter int unsigned      SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                step_input,
  output logic                step_set,
  output logic                busy,
  rc_meas_sequencer_if.master meas
);

  import rc_tdc_pkg::*;

  localparam int unsigned      ACC_W    = CNT_W + AVG_LOG2;
  localparam int unsigned      IDX_W    = AVG_LOG2 + 1;
  localparam int unsigned      X4_W     = CNT_W + DISCHARGE_SHIFT;
  localparam logic [CNT_W-1:0] CNT_ALL  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(1 << AVG_LOG2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             movf_q, movf_d;

  logic             sin;
  logic [X4_W-1:0]  sample_x4;
  logic [CNT_W-1:0] scaled;
  logic [CNT_W-1:0] hold;
  logic [ACC_W-1:0] acc_sum;
  logic [IDX_W-1:0] idx_next;

  rc_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (step_input),
    .q     (sin)
  );

  // Discharge hold scales with the last charge time, saturating rather than wrapping.
  always_comb begin
    sample_x4 = {sample_q, {DISCHARGE_SHIFT{1'b0}}};
    scaled    = (sample_x4[X4_W-1:CNT_W] != '0) ? CNT_ALL : sample_x4[CNT_W-1:0];
    hold      = (scaled > MIN_DISCHARGE) ? scaled : MIN_DISCHARGE;
    acc_sum   = acc_q + ACC_W'(sample_q);
    idx_next  = idx_q + IDX_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    sample_d = sample_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    movf_d   = movf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CHARGE;
          timer_d = '0;
          acc_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      CHARGE: begin
        if (sin) begin
          sample_d = timer_q;
          timer_d  = '0;
          state_d  = DISCHARGE;
        end else if (timer_q == CNT_ALL) begin
          sample_d = CNT_ALL;
          ovf_d    = 1'b1;
          timer_d  = '0;
          state_d  = DISCHARGE;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      DISCHARGE: begin
        if ((timer_q >= hold) && !sin) begin
          acc_d   = acc_sum;
          idx_d   = idx_next;
          timer_d = '0;
          if (idx_next == IDX_LAST) begin
            state_d = RESULT;
            count_d = CNT_W'(acc_sum >> AVG_LOG2);
            movf_d  = ovf_q;
          end else begin
            state_d = CHARGE;
          end
        end else if (timer_q != CNT_ALL) begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      RESULT: begin
        if (meas.meas_ready) begin
`ifdef RC_AUTORUN_EN
          state_d = CHARGE;
          timer_d = '0;
          acc_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      sample_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      movf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      sample_q <= sample_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      movf_q   <= movf_d;
    end
  end

  // Outputs decode the registered state so a reset edge drops excitation immediately.
  assign step_set           = (state_q == CHARGE);
  assign busy               = (state_q != IDLE);
  assign meas.meas_valid    = (state_q == RESULT);
  assign meas.meas_count    = count_q;
  assign meas.meas_overflow = movf_q;

endmodule

// File: tb/tb_rc_meas_sequencer.sv
// Self-checking bench: three sequencer configurations driven by a behavioural RC comparator model.
module tb_rc_meas_sequencer;

  localparam int          NCH   = 3;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned NEVER = 1000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] ready = '0;
  logic [NCH-1:0] step_in = '0;
  logic [NCH-1:0] step_set, busy, mvalid, movf;
  logic [23:0]    mcount [NCH];

  int total = 0;
  int bad   = 0;

  int unsigned dq     [NCH][$];
  int unsigned lowq   [NCH][$];
  int unsigned d_cur  [NCH];
  int unsigned fall_d [NCH];
  int unsigned hi_cnt [NCH];
  int unsigned lo_cnt [NCH];
  int unsigned lo_run [NCH];

  always #5 clk = ~clk;

  rc_meas_sequencer_if #(.CNT_W(24)) if0 ();
  rc_meas_sequencer_if #(.CNT_W(24)) if1 ();
  rc_meas_sequencer_if #(.CNT_W(8))  if2 ();

  assign if0.meas_ready = ready[0];
  assign if1.meas_ready = ready[1];
  assign if2.meas_ready = ready[2];
  assign mvalid = {if2.meas_valid, if1.meas_valid, if0.meas_valid};
  assign movf   = {if2.meas_overflow, if1.meas_overflow, if0.meas_overflow};
  assign mcount[0] = if0.meas_count;
  assign mcount[1] = if1.meas_count;
  assign mcount[2] = {16'd0, if2.meas_count};

  rc_meas_sequencer #(.CNT_W(24), .AVG_LOG2(0), .MIN_DISCHARGE(24'd1000), .SYNC_STAGES(2)) u_avg1 (
    .clk(clk), .reset(reset), .start(start[0]), .step_input(step_in[0]),
    .step_set(step_set[0]), .busy(busy[0]), .meas(if0)
  );
  rc_meas_sequencer #(.CNT_W(24), .AVG_LOG2(2), .MIN_DISCHARGE(24'd1000), .SYNC_STAGES(2)) u_avg4 (
    .clk(clk), .reset(reset), .start(start[1]), .step_input(step_in[1]),
    .step_set(step_set[1]), .busy(busy[1]), .meas(if1)
  );
  rc_meas_sequencer #(.CNT_W(8), .AVG_LOG2(0), .MIN_DISCHARGE(8'd100), .SYNC_STAGES(2)) u_w8 (
    .clk(clk), .reset(reset), .start(start[2]), .step_input(step_in[2]),
    .step_set(step_set[2]), .busy(busy[2]), .meas(if2)
  );

  function automatic int unsigned cmax(int c);
    return (c == 2) ? 255 : 24'hFF_FFFF;
  endfunction

  function automatic int unsigned mind(int c);
    return (c == 2) ? 100 : 1000;
  endfunction

  function automatic int unsigned exp_sample(int c, int unsigned d);
    longint t;
    t = longint'(d) + SYNC;
    return (t > cmax(c)) ? cmax(c) : int'(t);
  endfunction

  // Cycles step_set stays low: the hold time, stretched while the comparator is still high.
  function automatic int unsigned exp_low(int c, int unsigned s, bit rose, int unsigned fd);
    longint h;
    h = longint'(s) * 4;
    if (h > cmax(c)) h = cmax(c);
    if (h < mind(c)) h = mind(c);
    if (rose && (fd + SYNC > h)) h = fd + SYNC;
    return int'(h) + 1;
  endfunction

  // RC comparator: rises d cycles into a charge, falls fall_d cycles into a discharge.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        hi_cnt[c] = 0; lo_cnt[c] = 0; lo_run[c] = 0; step_in[c] = 1'b0;
        dq[c].delete(); lowq[c].delete();
      end else begin
        if (step_set[c]) begin
          if (hi_cnt[c] == 0) d_cur[c] = (dq[c].size() > 0) ? dq[c].pop_front() : NEVER;
          hi_cnt[c]++;
          lo_cnt[c] = 0;
          if (hi_cnt[c] > d_cur[c]) step_in[c] = 1'b1;
        end else begin
          hi_cnt[c] = 0;
          lo_cnt[c]++;
          if (lo_cnt[c] > fall_d[c]) step_in[c] = 1'b0;
        end
        if (busy[c] && !step_set[c] && !mvalid[c]) begin
          lo_run[c]++;
        end else if (lo_run[c] != 0) begin
          lowq[c].push_back(lo_run[c]);
          lo_run[c] = 0;
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle();
`ifdef RC_AUTORUN_EN
    apply_reset();
`else
    @(negedge clk);
`endif
  endtask

  task automatic measure(input int c, input int unsigned n, input int unsigned ds[4],
                         output logic [23:0] cnt, output logic ovf, output bit timeout);
    lowq[c].delete();
    for (int i = 0; i < int'(n); i++) dq[c].push_back(ds[i]);
    @(negedge clk) start[c] = 1'b1;
    @(negedge clk) start[c] = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 40000; k++) begin
      if (mvalid[c]) begin timeout = 1'b0; break; end
      @(negedge clk);
    end
    #1;
    cnt = mcount[c];
    ovf = movf[c];
  endtask

  task automatic handshake(input int c);
    @(negedge clk) ready[c] = 1'b1;
    @(negedge clk) ready[c] = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < NCH; c++) begin
      total++;
      if ({step_set[c], busy[c], mvalid[c], movf[c]} !== 4'b0000) begin
        bad++; $display("FAIL reset_flags ch%0d: got %b want 0000", c, {step_set[c], busy[c], mvalid[c], movf[c]});
      end
      total++;
      if (mcount[c] !== 24'd0) begin bad++; $display("FAIL reset_count ch%0d: got %0d want 0", c, mcount[c]); end
    end
  endtask

  task automatic test_single();
    logic [23:0] cnt; logic ovf; bit to;
    int unsigned ds[4], es, lw;
    for (int it = 0; it < 3; it++) begin
      ds = '{(it == 0) ? 100 : $urandom_range(300, 20), 0, 0, 0};
      fall_d[0] = $urandom_range(900, 0);
      measure(0, 1, ds, cnt, ovf, to);
      es = exp_sample(0, ds[0]);
      total++; if (to) begin bad++; $display("FAIL single_timeout it%0d: valid=0 want 1", it); end
      total++; if (cnt !== 24'(es)) begin bad++; $display("FAIL single_count it%0d: got %0d want %0d", it, cnt, es); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL single_ovf it%0d: got %b want 0", it, ovf); end
      lw = (lowq[0].size() == 1) ? lowq[0][0] : 0;
      total++;
      if (lw != exp_low(0, es, 1'b1, fall_d[0])) begin
        bad++; $display("FAIL single_low it%0d: got %0d want %0d", it, lw, exp_low(0, es, 1'b1, fall_d[0]));
      end
      handshake(0);
      total++; if (mvalid[0] !== 1'b0) begin bad++; $display("FAIL single_valid_drop it%0d: got %b want 0", it, mvalid[0]); end
`ifndef RC_AUTORUN_EN
      total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL single_busy_drop it%0d: got %b want 0", it, busy[0]); end
`endif
      settle();
    end
  endtask

  task automatic test_avg();
    logic [23:0] cnt; logic ovf; bit to;
    int unsigned ds[4], sum, es[4], lw;
    for (int it = 0; it < 2; it++) begin
      if (it == 0) ds = '{100, 104, 108, 112};
      else for (int i = 0; i < 4; i++) ds[i] = $urandom_range(300, 20);
      fall_d[1] = $urandom_range(900, 0);
      sum = 0;
      for (int i = 0; i < 4; i++) begin es[i] = exp_sample(1, ds[i]); sum += es[i]; end
      measure(1, 4, ds, cnt, ovf, to);
      total++; if (to) begin bad++; $display("FAIL avg_timeout it%0d: valid=0 want 1", it); end
      total++; if (cnt !== 24'(sum >> 2)) begin bad++; $display("FAIL avg_count it%0d: got %0d want %0d", it, cnt, sum >> 2); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL avg_ovf it%0d: got %b want 0", it, ovf); end
      for (int i = 0; i < 4; i++) begin
        lw = (lowq[1].size() == 4) ? lowq[1][i] : 0;
        total++;
        if (lw != exp_low(1, es[i], 1'b1, fall_d[1])) begin
          bad++; $display("FAIL avg_low it%0d s%0d: got %0d want %0d", it, i, lw, exp_low(1, es[i], 1'b1, fall_d[1]));
        end
      end
      handshake(1);
`ifndef RC_AUTORUN_EN
      total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL avg_busy_drop it%0d: got %b want 0", it, busy[1]); end
`endif
      settle();
    end
  endtask

  task automatic test_overflow();
    logic [23:0] cnt; logic ovf; bit to;
    int unsigned ds[4], es, lw;
    bit rose;
    for (int it = 0; it < 2; it++) begin
      ds = '{(it == 0) ? NEVER : 50, 0, 0, 0};
      rose = (it != 0);
      fall_d[2] = $urandom_range(300, 0);
      es = exp_sample(2, ds[0]);
      measure(2, 1, ds, cnt, ovf, to);
      total++; if (to) begin bad++; $display("FAIL ovf_timeout it%0d: valid=0 want 1", it); end
      total++; if (cnt !== 24'(es)) begin bad++; $display("FAIL ovf_count it%0d: got %0d want %0d", it, cnt, es); end
      total++; if (ovf !== !rose) begin bad++; $display("FAIL ovf_flag it%0d: got %b want %b", it, ovf, !rose); end
      lw = (lowq[2].size() == 1) ? lowq[2][0] : 0;
      total++;
      if (lw != exp_low(2, es, rose, fall_d[2])) begin
        bad++; $display("FAIL ovf_low it%0d: got %0d want %0d", it, lw, exp_low(2, es, rose, fall_d[2]));
      end
      handshake(2);
      settle();
    end
  endtask

  task automatic test_ready_hold();
    logic [23:0] cnt; logic ovf; bit to;
    int unsigned ds[4], es;
    int vbad, cbad;
    ds = '{$urandom_range(300, 20), 0, 0, 0};
    fall_d[0] = $urandom_range(900, 0);
    es = exp_sample(0, ds[0]);
    measure(0, 1, ds, cnt, ovf, to);
    total++; if (to) begin bad++; $display("FAIL hold_timeout: valid=0 want 1"); end
    vbad = 0; cbad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start[0] = (k == 10);
      if (mvalid[0] !== 1'b1) vbad++;
      if (mcount[0] !== 24'(es)) cbad++;
    end
    start[0] = 1'b0;
    total++; if (vbad != 0) begin bad++; $display("FAIL hold_valid: dropped in %0d cycles want 0", vbad); end
    total++; if (cbad != 0) begin bad++; $display("FAIL hold_count: unstable in %0d cycles want 0 (want %0d)", cbad, es); end
    handshake(0);
    total++; if (mvalid[0] !== 1'b0) begin bad++; $display("FAIL hold_valid_drop: got %b want 0", mvalid[0]); end
    total++; if (mcount[0] !== 24'(es)) begin bad++; $display("FAIL hold_count_after: got %0d want %0d", mcount[0], es); end
`ifndef RC_AUTORUN_EN
    repeat (3) @(negedge clk);
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL hold_start_ignored: busy=%b want 0", busy[0]); end
`endif
    settle();
  endtask

  task automatic test_reset_mid();
    logic [23:0] cnt; logic ovf; bit to;
    int unsigned ds[4];
    bit seen;
    dq[0].push_back(500);
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (step_set[0]) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_charge_start: step_set=0 want 1"); end
    repeat (37) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({step_set[0], busy[0], mvalid[0]} !== 3'b000) begin
      bad++; $display("FAIL mid_reset: got %b want 000", {step_set[0], busy[0], mvalid[0]});
    end
    @(negedge clk) reset = 1'b0;
    ds = '{60, 0, 0, 0};
    fall_d[0] = $urandom_range(900, 0);
    measure(0, 1, ds, cnt, ovf, to);
    total++; if (to) begin bad++; $display("FAIL mid_after_timeout: valid=0 want 1"); end
    total++; if (cnt !== 24'(exp_sample(0, 60))) begin bad++; $display("FAIL mid_after_count: got %0d want %0d", cnt, exp_sample(0, 60)); end
    handshake(0);
    settle();
  endtask

  task automatic test_back_to_back();
    logic [23:0] cnt; logic ovf; bit to;
    int unsigned ds[4], sum;
    ready[1] = 1'b1;
    for (int it = 0; it < 2; it++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin ds[i] = $urandom_range(200, 20); sum += exp_sample(1, ds[i]); end
      fall_d[1] = $urandom_range(600, 0);
      measure(1, 4, ds, cnt, ovf, to);
      total++; if (to) begin bad++; $display("FAIL b2b_timeout it%0d: valid=0 want 1", it); end
      total++; if (cnt !== 24'(sum >> 2)) begin bad++; $display("FAIL b2b_count it%0d: got %0d want %0d", it, cnt, sum >> 2); end
      @(negedge clk);
      total++; if (mvalid[1] !== 1'b0) begin bad++; $display("FAIL b2b_one_cycle it%0d: valid=%b want 0", it, mvalid[1]); end
      total++; if (mcount[1] !== 24'(sum >> 2)) begin bad++; $display("FAIL b2b_count_hold it%0d: got %0d want %0d", it, mcount[1], sum >> 2); end
`ifdef RC_AUTORUN_EN
      apply_reset();
`endif
    end
    ready[1] = 1'b0;
    settle();
  endtask

`ifdef RC_AUTORUN_EN
  task automatic test_autorun();
    int unsigned ds[3], es;
    bit got;
    for (int i = 0; i < 3; i++) begin ds[i] = $urandom_range(200, 20); dq[0].push_back(ds[i]); end
    fall_d[0] = $urandom_range(600, 0);
    ready[0] = 1'b1;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      es = exp_sample(0, ds[r]);
      got = 1'b0;
      for (int k = 0; k < 20000; k++) begin
        if (mvalid[0]) begin got = 1'b1; break; end
        @(negedge clk);
      end
      total++; if (!got) begin bad++; $display("FAIL auto_timeout r%0d: valid=0 want 1", r); end
      total++; if (mcount[0] !== 24'(es)) begin bad++; $display("FAIL auto_count r%0d: got %0d want %0d", r, mcount[0], es); end
      @(negedge clk);
      total++;
      if ({mvalid[0], step_set[0]} !== 2'b01) begin
        bad++; $display("FAIL auto_restart r%0d: valid,step_set=%b want 01", r, {mvalid[0], step_set[0]});
      end
    end
    ready[0] = 1'b0;
    apply_reset();
  endtask
`endif

  initial begin
    for (int c = 0; c < NCH; c++) begin
      fall_d[c] = 0; d_cur[c] = NEVER; hi_cnt[c] = 0; lo_cnt[c] = 0; lo_run[c] = 0;
    end
    test_reset();
    test_single();
    test_avg();
    test_overflow();
    test_ready_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef RC_AUTORUN_EN
    test_autorun();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
